// File: rtl/ti_link_pkg.sv
// Shared TI link protocol constants, FSM state encoding and command classification.
package ti_link_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned STATE_W = 3;

    // Header-only commands
    localparam logic [BYTE_W-1:0] CMD_ACK  = 8'h56;
    localparam logic [BYTE_W-1:0] CMD_CTS  = 8'h09;
    localparam logic [BYTE_W-1:0] CMD_ERR  = 8'h5A;
    localparam logic [BYTE_W-1:0] CMD_RDY  = 8'h68;
    localparam logic [BYTE_W-1:0] CMD_EOT  = 8'h92;

    // Data-carrying commands
    localparam logic [BYTE_W-1:0] CMD_VAR  = 8'h06;
    localparam logic [BYTE_W-1:0] CMD_DATA = 8'h15;
    localparam logic [BYTE_W-1:0] CMD_SKP  = 8'h36;
    localparam logic [BYTE_W-1:0] CMD_DEL  = 8'h88;
    localparam logic [BYTE_W-1:0] CMD_REQ  = 8'hA2;
    localparam logic [BYTE_W-1:0] CMD_RTS  = 8'hC9;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_LEN_HI = 3'd3,
        ST_DATA   = 3'd4,
        ST_CK_LO  = 3'd5,
        ST_CK_HI  = 3'd6
    } state_t;

    // True for commands followed by a payload and checksum trailer
    function automatic logic is_data_cmd(input logic [BYTE_W-1:0] cmd);
        case (cmd)
            CMD_VAR, CMD_DATA, CMD_SKP, CMD_DEL, CMD_REQ, CMD_RTS: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/byte_handshake_rx.sv
// Level/acknowledge byte receiver for the dbus interface: one strobe per offered byte.
module byte_handshake_rx
    import ti_link_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_avail,
    output logic              o_read,
    output logic              o_byte_valid_c,
    output logic [BYTE_W-1:0] o_byte_c
);

    logic r_avail;
    logic r_read;
    logic w_capture;

    // A byte is taken once per avail level; the consumer latches o_byte_c on this strobe
    assign w_capture      = r_avail && !r_read;
    assign o_byte_valid_c = w_capture;
    assign o_byte_c       = i_data;
    assign o_read         = r_read;

    // Register avail and hold the acknowledge until dbus withdraws the byte
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_avail <= 1'b0;
            r_read  <= 1'b0;
        end else begin
            r_avail <= i_avail;
            if (w_capture) begin
                r_read <= 1'b1;
            end else if (!r_avail) begin
                r_read <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ti_link_packet_rx.sv
// TI link packet parser: header decode, payload strobes, checksum verdict, inter-byte timeout.
module ti_link_packet_rx
    import ti_link_pkg::*;
#(
    parameter int unsigned c_TIMEOUT = 1000000,
    parameter int unsigned c_TOWIDTH = 20
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_avail,
    output logic              o_read,
    output logic [BYTE_W-1:0] o_machine,
    output logic [BYTE_W-1:0] o_command,
    output logic [LEN_W-1:0]  o_length,
    output logic              o_hdr_valid,
    output logic [BYTE_W-1:0] o_payload,
    output logic              o_payload_valid,
    output logic              o_done,
    output logic              o_cksum_err,
    output logic              o_timeout,
    output logic              o_busy
);

    logic                 w_byte_valid;
    logic [BYTE_W-1:0]    w_byte;
    logic [LEN_W-1:0]     w_len_full;

    state_t               r_state;
    logic [BYTE_W-1:0]    r_machine;
    logic [BYTE_W-1:0]    r_command;
    logic [LEN_W-1:0]     r_length;
    logic                 r_hdr_valid;
    logic [BYTE_W-1:0]    r_payload;
    logic                 r_payload_valid;
    logic                 r_done;
    logic                 r_cksum_err;
    logic                 r_timeout;
    logic                 r_busy;
    logic [LEN_W-1:0]     r_sum;
    logic [LEN_W-1:0]     r_remain;
    logic [BYTE_W-1:0]    r_ck_lo;
    logic [c_TOWIDTH-1:0] r_to_cnt;

    byte_handshake_rx u_hs (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_data         (i_data),
        .i_avail        (i_avail),
        .o_read         (o_read),
        .o_byte_valid_c (w_byte_valid),
        .o_byte_c       (w_byte)
    );

    // Length as it will read once the high byte now on the bus is stored
    assign w_len_full = {w_byte, r_length[BYTE_W-1:0]};

    // Packet FSM, checksum accumulation and inter-byte timeout; advances once per captured byte
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_machine       <= '0;
            r_command       <= '0;
            r_length        <= '0;
            r_hdr_valid     <= 1'b0;
            r_payload       <= '0;
            r_payload_valid <= 1'b0;
            r_done          <= 1'b0;
            r_cksum_err     <= 1'b0;
            r_timeout       <= 1'b0;
            r_busy          <= 1'b0;
            r_sum           <= '0;
            r_remain        <= '0;
            r_ck_lo         <= '0;
            r_to_cnt        <= '0;
        end else begin
            r_hdr_valid     <= 1'b0;
            r_payload_valid <= 1'b0;
            r_done          <= 1'b0;
            r_cksum_err     <= 1'b0;
            r_timeout       <= 1'b0;

            if (w_byte_valid) begin
                // A capture always wins over an expiring timeout
                r_to_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        r_machine <= w_byte;
                        r_sum     <= '0;
                        r_remain  <= '0;
                        r_state   <= ST_CMD;
                        r_busy    <= 1'b1;
                    end
                    ST_CMD: begin
                        r_command <= w_byte;
                        r_state   <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        r_length[BYTE_W-1:0] <= w_byte;
                        r_state              <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        r_length[LEN_W-1:BYTE_W] <= w_byte;
                        r_hdr_valid              <= 1'b1;
                        if (!is_data_cmd(r_command)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_len_full == '0) begin
                            r_state <= ST_CK_LO;
                        end else begin
                            r_remain <= w_len_full;
                            r_state  <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_payload       <= w_byte;
                        r_payload_valid <= 1'b1;
                        r_sum           <= r_sum + {BYTE_W'(0), w_byte};
                        r_remain        <= r_remain - LEN_W'(1);
                        if (r_remain == LEN_W'(1)) begin
                            r_state <= ST_CK_LO;
                        end
                    end
                    ST_CK_LO: begin
                        r_ck_lo <= w_byte;
                        r_state <= ST_CK_HI;
                    end
                    ST_CK_HI: begin
                        r_done      <= 1'b1;
                        r_cksum_err <= ({w_byte, r_ck_lo} != r_sum);
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (r_state == ST_IDLE) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == c_TOWIDTH'(c_TIMEOUT - 1)) begin
                r_timeout <= 1'b1;
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_to_cnt  <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TOWIDTH'(1);
            end
        end
    end

    assign o_machine       = r_machine;
    assign o_command       = r_command;
    assign o_length        = r_length;
    assign o_hdr_valid     = r_hdr_valid;
    assign o_payload       = r_payload;
    assign o_payload_valid = r_payload_valid;
    assign o_done          = r_done;
    assign o_cksum_err     = r_cksum_err;
    assign o_timeout       = r_timeout;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_ti_link_packet_rx.sv
// Directed bench for ti_link_packet_rx with a level/acknowledge dbus byte source.
module tb_ti_link_packet_rx;

    localparam int unsigned TO = 50;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_data  = 8'h00;
    logic        i_avail = 1'b0;
    logic        o_read;
    logic [7:0]  o_machine;
    logic [7:0]  o_command;
    logic [15:0] o_length;
    logic        o_hdr_valid;
    logic [7:0]  o_payload;
    logic        o_payload_valid;
    logic        o_done;
    logic        o_cksum_err;
    logic        o_timeout;
    logic        o_busy;

    ti_link_packet_rx #(.c_TIMEOUT(TO), .c_TOWIDTH(20)) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_data          (i_data),
        .i_avail         (i_avail),
        .o_read          (o_read),
        .o_machine       (o_machine),
        .o_command       (o_command),
        .o_length        (o_length),
        .o_hdr_valid     (o_hdr_valid),
        .o_payload       (o_payload),
        .o_payload_valid (o_payload_valid),
        .o_done          (o_done),
        .o_cksum_err     (o_cksum_err),
        .o_timeout       (o_timeout),
        .o_busy          (o_busy)
    );

    always #5 i_clock = ~i_clock;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         hdr_cnt  = 0;
    int         hdr_cyc  = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         to_cnt   = 0;
    int         to_cyc   = 0;
    int         pay_cyc  = 0;
    logic       done_err = 1'b0;
    logic [7:0] pay_q[$];
    logic [7:0] tx_q[$];

    // Record every strobe with the cycle it was seen in
    always @(negedge i_clock) begin
        cyc <= cyc + 1;
        if (o_hdr_valid) begin
            hdr_cnt <= hdr_cnt + 1;
            hdr_cyc <= cyc;
        end
        if (o_payload_valid) begin
            pay_q.push_back(o_payload);
            pay_cyc <= cyc;
        end
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_err <= o_cksum_err;
        end
        if (o_timeout) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte, optionally keep avail high for extra cycles after the acknowledge
    task automatic send_byte(input logic [7:0] b, input int hold);
        int n;
        @(negedge i_clock);
        i_data  = b;
        i_avail = 1'b1;
        n = 0;
        while (!o_read && n < 100) begin
            @(negedge i_clock);
            n++;
        end
        chk("read_rise", {31'd0, o_read}, 32'd1);
        repeat (hold) @(negedge i_clock);
        i_avail = 1'b0;
        n = 0;
        while (o_read && n < 100) begin
            @(negedge i_clock);
            n++;
        end
        chk("read_fall", {31'd0, o_read}, 32'd0);
    endtask

    task automatic send_q(input int hold);
        foreach (tx_q[i]) send_byte(tx_q[i], hold);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_read"},    {31'd0, o_read},          32'd0);
        chk({tag, "_machine"}, {24'd0, o_machine},       32'd0);
        chk({tag, "_command"}, {24'd0, o_command},       32'd0);
        chk({tag, "_length"},  {16'd0, o_length},        32'd0);
        chk({tag, "_hdr"},     {31'd0, o_hdr_valid},     32'd0);
        chk({tag, "_payload"}, {24'd0, o_payload},       32'd0);
        chk({tag, "_pvalid"},  {31'd0, o_payload_valid}, 32'd0);
        chk({tag, "_done"},    {31'd0, o_done},          32'd0);
        chk({tag, "_ckerr"},   {31'd0, o_cksum_err},     32'd0);
        chk({tag, "_timeout"}, {31'd0, o_timeout},       32'd0);
        chk({tag, "_busy"},    {31'd0, o_busy},          32'd0);
    endtask

    initial begin
        int b_hdr;
        int b_done;
        int b_pay;
        int b_to;
        int bad;

        // Reset state
        repeat (3) @(negedge i_clock);
        chk_idle_outputs("rst");
        i_reset = 1'b0;
        repeat (2) @(negedge i_clock);

        // Header-only ACK: done coincides with hdr_valid, no payload
        b_hdr = hdr_cnt; b_done = done_cnt; b_pay = pay_q.size();
        tx_q = '{8'h73, 8'h56, 8'h00, 8'h00};
        send_q(0);
        repeat (3) @(negedge i_clock);
        chk("ack_hdr_cnt",  32'(hdr_cnt - b_hdr),   32'd1);
        chk("ack_machine",  {24'd0, o_machine},     32'h73);
        chk("ack_command",  {24'd0, o_command},     32'h56);
        chk("ack_length",   {16'd0, o_length},      32'h0);
        chk("ack_done_cnt", 32'(done_cnt - b_done), 32'd1);
        chk("ack_ckerr",    {31'd0, done_err},      32'd0);
        chk("ack_same_cyc", 32'(done_cyc),          32'(hdr_cyc));
        chk("ack_no_pay",   32'(pay_q.size() - b_pay), 32'd0);
        chk("ack_busy",     {31'd0, o_busy},        32'd0);

        // VAR packet with a correct checksum (1+2+3 = 6)
        b_done = done_cnt; b_pay = pay_q.size();
        send_byte(8'h73, 0);
        chk("var_busy_mid", {31'd0, o_busy}, 32'd1);
        tx_q = '{8'h06, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06, 8'h00};
        send_q(0);
        repeat (3) @(negedge i_clock);
        chk("var_pay_cnt", 32'(pay_q.size() - b_pay), 32'd3);
        if (pay_q.size() - b_pay == 3) begin
            chk("var_pay0", {24'd0, pay_q[b_pay]},     32'h01);
            chk("var_pay1", {24'd0, pay_q[b_pay + 1]}, 32'h02);
            chk("var_pay2", {24'd0, pay_q[b_pay + 2]}, 32'h03);
        end
        chk("var_command",  {24'd0, o_command},     32'h06);
        chk("var_length",   {16'd0, o_length},      32'h3);
        chk("var_done_cnt", 32'(done_cnt - b_done), 32'd1);
        chk("var_ckerr",    {31'd0, done_err},      32'd0);

        // Same packet with a wrong trailer, then a clean ACK
        b_done = done_cnt;
        tx_q = '{8'h73, 8'h06, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h00};
        send_q(0);
        repeat (3) @(negedge i_clock);
        chk("bad_done_cnt", 32'(done_cnt - b_done), 32'd1);
        chk("bad_ckerr",    {31'd0, done_err},      32'd1);
        b_done = done_cnt;
        tx_q = '{8'h73, 8'h56, 8'h00, 8'h00};
        send_q(0);
        repeat (3) @(negedge i_clock);
        chk("ack2_done_cnt", 32'(done_cnt - b_done), 32'd1);
        chk("ack2_ckerr",    {31'd0, done_err},      32'd0);
        chk("ack2_command",  {24'd0, o_command},     32'h56);

        // 0x0102 bytes of 0xFF: 258*255 = 0x100FE, which wraps to 0x00FE
        b_done = done_cnt; b_pay = pay_q.size();
        tx_q = '{8'h73, 8'h15, 8'h02, 8'h01};
        for (int i = 0; i < 258; i++) tx_q.push_back(8'hFF);
        tx_q.push_back(8'hFE);
        tx_q.push_back(8'h00);
        send_q(0);
        repeat (3) @(negedge i_clock);
        chk("wrap_length",   {16'd0, o_length},      32'h0102);
        chk("wrap_pay_cnt",  32'(pay_q.size() - b_pay), 32'd258);
        bad = 0;
        for (int i = 0; i < 258; i++) begin
            if (b_pay + i < pay_q.size()) begin
                if (pay_q[b_pay + i] !== 8'hFF) bad++;
            end else begin
                bad++;
            end
        end
        chk("wrap_pay_ff",   32'(bad),               32'd0);
        chk("wrap_done_cnt", 32'(done_cnt - b_done), 32'd1);
        chk("wrap_ckerr",    {31'd0, done_err},      32'd0);

        // Timeout: stall after the first of two payload bytes
        b_done = done_cnt; b_to = to_cnt;
        tx_q = '{8'h73, 8'h15, 8'h02, 8'h00, 8'hAA};
        send_q(0);
        for (int n = 0; n < 200 && to_cnt == b_to; n++) @(negedge i_clock);
        @(negedge i_clock);
        chk("to_cnt",      32'(to_cnt - b_to),     32'd1);
        chk("to_latency",  32'(to_cyc - pay_cyc),  32'(TO));
        chk("to_busy",     {31'd0, o_busy},        32'd0);
        chk("to_no_done",  32'(done_cnt - b_done), 32'd0);
        chk("to_last_pay", {24'd0, pay_q[$]},      32'hAA);
        tx_q = '{8'h73, 8'h68, 8'h00, 8'h00};
        send_q(0);
        repeat (3) @(negedge i_clock);
        chk("to_next_done", 32'(done_cnt - b_done), 32'd1);
        chk("to_next_cmd",  {24'd0, o_command},     32'h68);

        // Reset after 2 of 5 payload bytes abandons the packet silently
        b_done = done_cnt; b_to = to_cnt; b_pay = pay_q.size();
        tx_q = '{8'h73, 8'h15, 8'h05, 8'h00, 8'h11, 8'h22};
        send_q(0);
        chk("rmid_pay_cnt", 32'(pay_q.size() - b_pay), 32'd2);
        chk("rmid_busy",    {31'd0, o_busy},           32'd1);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        chk_idle_outputs("rmid");
        i_reset = 1'b0;
        repeat (2 * TO) @(negedge i_clock);
        chk("rmid_no_done", 32'(done_cnt - b_done), 32'd0);
        chk("rmid_no_to",   32'(to_cnt - b_to),     32'd0);

        // Slow handshake: avail held 10 extra cycles per byte, sum 0x5A+0xA5 = 0x00FF
        b_done = done_cnt; b_pay = pay_q.size(); b_hdr = hdr_cnt;
        tx_q = '{8'h42, 8'h15, 8'h02, 8'h00, 8'h5A, 8'hA5, 8'hFF, 8'h00};
        send_q(10);
        repeat (3) @(negedge i_clock);
        chk("slow_hdr_cnt",  32'(hdr_cnt - b_hdr),      32'd1);
        chk("slow_machine",  {24'd0, o_machine},        32'h42);
        chk("slow_pay_cnt",  32'(pay_q.size() - b_pay), 32'd2);
        chk("slow_done_cnt", 32'(done_cnt - b_done),    32'd1);
        chk("slow_ckerr",    {31'd0, done_err},         32'd0);

        // Length-0 DATA packet: checksum expected 0x0000
        b_done = done_cnt; b_pay = pay_q.size();
        tx_q = '{8'h73, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00};
        send_q(0);
        repeat (3) @(negedge i_clock);
        chk("len0_done_cnt", 32'(done_cnt - b_done),    32'd1);
        chk("len0_ckerr",    {31'd0, done_err},         32'd0);
        chk("len0_no_pay",   32'(pay_q.size() - b_pay), 32'd0);
        chk("len0_busy",     {31'd0, o_busy},           32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
